// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute-facing signals of the branch resolve queue.
// Handshakes:
//   enqueue fires on a clock edge where enq_valid && enq_ready (enq_ready depends only on registered state);
//   resolve fires where res_valid && the queue is non-empty.
//   rslt_en/rslt_pc/rslt_taken/mispredict are registered and valid for exactly one cycle after a resolve fires.
interface branch_resolve_queue_if #(
  parameter int PC_W = 15
);
  logic            enq_valid;
  logic [PC_W-1:0] enq_pc;
  logic            enq_pred_taken;
  logic            enq_ready;
  logic            res_valid;
  logic            res_taken;
  logic            flush;
  logic            rslt_en;
  logic [PC_W-1:0] rslt_pc;
  logic            rslt_taken;
  logic            mispredict;

  modport master (
    output enq_valid, enq_pc, enq_pred_taken, res_valid, res_taken, flush,
    input  enq_ready, rslt_en, rslt_pc, rslt_taken, mispredict
  );

  modport slave (
    input  enq_valid, enq_pc, enq_pred_taken, res_valid, res_taken, flush,
    output enq_ready, rslt_en, rslt_pc, rslt_taken, mispredict
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted conditional branches; resolves the oldest entry,
// drives the predictor update port, squashes younger entries on mispredict.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 15,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  branch_resolve_queue_if.slave        bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         underflow_err,
  output logic [CNT_W-1:0]             resolve_cnt,
  output logic [CNT_W-1:0]             mispred_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PC_W-1:0] pc_mem   [DEPTH];
  logic            pred_mem [DEPTH];

  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rslt_en_q, rslt_en_d;
  logic [PC_W-1:0]  rslt_pc_q, rslt_pc_d;
  logic             rslt_taken_q, rslt_taken_d;
  logic             mispredict_q, mispredict_d;
  logic             underflow_q, underflow_d;
  logic [CNT_W-1:0] resolve_cnt_q, resolve_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic            enq_ready;
  logic            enq_fire;
  logic            res_fire;
  logic            mis_now;
  logic            wr_en;
  logic [AW-1:0]   head_inc;
  logic [PC_W-1:0] head_pc;
  logic            head_pred;

  always_comb begin
    enq_ready = (count_q != FULL);
    enq_fire  = bus.enq_valid && enq_ready;
    res_fire  = bus.res_valid && (count_q != '0);
    head_pc   = pc_mem[head_q];
    head_pred = pred_mem[head_q];
    mis_now   = res_fire && (bus.res_taken != head_pred);
    head_inc  = head_q + 1'b1;
  end

  // Flush and mispredict both empty the queue; tail lands just past any entry resolved this cycle.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wr_en   = 1'b0;
    if (res_fire) begin
      head_d = head_inc;
    end
    if (bus.flush) begin
      count_d = '0;
      tail_d  = res_fire ? head_inc : head_q;
    end else if (mis_now) begin
      count_d = '0;
      tail_d  = head_inc;
    end else begin
      wr_en = enq_fire;
      if (enq_fire) begin
        tail_d = tail_q + 1'b1;
      end
      if (enq_fire && !res_fire) begin
        count_d = count_q + 1'b1;
      end else if (!enq_fire && res_fire) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_comb begin
    rslt_en_d     = res_fire;
    rslt_pc_d     = res_fire ? head_pc : rslt_pc_q;
    rslt_taken_d  = res_fire ? bus.res_taken : rslt_taken_q;
    mispredict_d  = mis_now;
    underflow_d   = underflow_q | (bus.res_valid && (count_q == '0));
    resolve_cnt_d = resolve_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    // Statistics saturate at all-ones rather than wrapping.
    if (res_fire && !(&resolve_cnt_q)) begin
      resolve_cnt_d = resolve_cnt_q + 1'b1;
    end
    if (mis_now && !(&mispred_cnt_q)) begin
      mispred_cnt_d = mispred_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      rslt_en_q     <= 1'b0;
      rslt_pc_q     <= '0;
      rslt_taken_q  <= 1'b0;
      mispredict_q  <= 1'b0;
      underflow_q   <= 1'b0;
      resolve_cnt_q <= '0;
      mispred_cnt_q <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      rslt_en_q     <= rslt_en_d;
      rslt_pc_q     <= rslt_pc_d;
      rslt_taken_q  <= rslt_taken_d;
      mispredict_q  <= mispredict_d;
      underflow_q   <= underflow_d;
      resolve_cnt_q <= resolve_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by count/head/tail.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[tail_q]   <= bus.enq_pc;
      pred_mem[tail_q] <= bus.enq_pred_taken;
    end
  end

  assign bus.enq_ready  = enq_ready;
  assign bus.rslt_en    = rslt_en_q;
  assign bus.rslt_pc    = rslt_pc_q;
  assign bus.rslt_taken = rslt_taken_q;
  assign bus.mispredict = mispredict_q;
  assign count          = count_q;
  assign underflow_err  = underflow_q;
  assign resolve_cnt    = resolve_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios plus random traffic,
// checked cycle by cycle against a queue-based reference model.
module tb_branch_resolve_queue;
  localparam int DEPTH = 4;
  localparam int PC_W  = 15;
  localparam int CNT_W = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int SAT   = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  branch_resolve_queue_if #(.PC_W(PC_W)) bus();
  logic [CW-1:0]    count;
  logic             underflow_err;
  logic [CNT_W-1:0] resolve_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .bus           (bus.slave),
    .count         (count),
    .underflow_err (underflow_err),
    .resolve_cnt   (resolve_cnt),
    .mispred_cnt   (mispred_cnt)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [PC_W-1:0] pc;
    logic            pred;
  } entry_t;

  entry_t          model_q[$];
  logic [PC_W+1:0] exp_q[$];   // {mispredict, taken, pc} of each expected update pulse
  int              m_res;
  int              m_mis;
  bit              m_uf;
  bit              exp_en;
  int              checks;
  int              failures;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    m_res  = 0;
    m_mis  = 0;
    m_uf   = 1'b0;
    exp_en = 1'b0;
  endtask

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  function automatic bit head_pred();
    return (model_q.size() != 0) ? model_q[0].pred : 1'b0;
  endfunction

  task automatic compare_all();
    logic [PC_W+1:0] pkt;
    check("enq_ready", 32'(bus.enq_ready), 32'(model_q.size() != DEPTH));
    check("count", 32'(count), 32'(model_q.size()));
    check("underflow_err", 32'(underflow_err), 32'(m_uf));
    check("resolve_cnt", 32'(resolve_cnt), 32'(sat(m_res)));
    check("mispred_cnt", 32'(mispred_cnt), 32'(sat(m_mis)));
    check("rslt_en", 32'(bus.rslt_en), 32'(exp_en));
    if (exp_en && exp_q.size() != 0) begin
      pkt = exp_q.pop_front();
      check("rslt_pc", 32'(bus.rslt_pc), 32'(pkt[PC_W-1:0]));
      check("rslt_taken", 32'(bus.rslt_taken), 32'(pkt[PC_W]));
      check("mispredict", 32'(bus.mispredict), 32'(pkt[PC_W+1]));
    end else begin
      check("mispredict_idle", 32'(bus.mispredict), 32'(0));
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit ev, input logic [PC_W-1:0] pc, input bit pt,
                       input bit rv, input bit rt, input bit fl);
    bit     enq_fire;
    bit     res_fire;
    bit     mis;
    entry_t h;
    bus.enq_valid      = ev;
    bus.enq_pc         = pc;
    bus.enq_pred_taken = pt;
    bus.res_valid      = rv;
    bus.res_taken      = rt;
    bus.flush          = fl;
    enq_fire = ev && (model_q.size() != DEPTH);
    res_fire = rv && (model_q.size() != 0);
    mis      = 1'b0;
    if (rv && model_q.size() == 0) m_uf = 1'b1;
    if (res_fire) begin
      h   = model_q.pop_front();
      mis = (rt != h.pred);
      exp_q.push_back({mis, rt, h.pc});
      m_res++;
      if (mis) m_mis++;
    end
    if (fl || mis) model_q.delete();
    else if (enq_fire) model_q.push_back('{pc, pt});
    exp_en = res_fire;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve_ok();
    cycle(1'b0, '0, 1'b0, 1'b1, head_pred(), 1'b0);
  endtask

  task automatic do_reset();
    bus.enq_valid = 1'b0; bus.enq_pc = '0; bus.enq_pred_taken = 1'b0;
    bus.res_valid = 1'b0; bus.res_taken = 1'b0; bus.flush = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    #1;
    compare_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    do_reset();
    check("reset_rslt_pc", 32'(bus.rslt_pc), 32'(0));
    check("reset_rslt_taken", 32'(bus.rslt_taken), 32'(0));

    // In-order resolves, all correct
    cycle(1'b1, PC_W'('h10), 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, PC_W'('h20), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, PC_W'('h30), 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    check("tp1_resolve_cnt", 32'(resolve_cnt), 32'(3));

    // Full queue rejects an enqueue even when a resolve frees a slot
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, PC_W'('h40 + 4*i), i[0], 1'b0, 1'b0, 1'b0);
    check("full_ready", 32'(bus.enq_ready), 32'(0));
    check("full_count", 32'(count), 32'(DEPTH));
    cycle(1'b1, PC_W'('h80), 1'b0, 1'b1, head_pred(), 1'b0);
    check("full_after_count", 32'(count), 32'(DEPTH-1));
    while (model_q.size() != 0) resolve_ok();
    idle();

    // Mispredict squashes younger entries and the concurrent enqueue
    cycle(1'b1, PC_W'('h100), 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, PC_W'('h104), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, PC_W'('h108), 1'b0, 1'b1, 1'b0, 1'b0);
    check("mis_pulse", 32'(bus.mispredict), 32'(1));
    check("mis_count", 32'(count), 32'(0));
    check("mis_cnt", 32'(mispred_cnt), 32'(1));
    idle();

    // Flush together with a correct resolve, then wrap the pointers
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, PC_W'('h200 + 4*i), 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("flush_pc", 32'(bus.rslt_pc), 32'('h200));
    check("flush_count", 32'(count), 32'(0));
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, PC_W'('h300 + 4*i), i[0], 1'b0, 1'b0, 1'b0);
      resolve_ok();
    end
    cycle(1'b1, PC_W'('h380), 1'b1, 1'b0, 1'b0, 1'b1);
    idle();

    // Resolve while empty sets the sticky error
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("uf_set", 32'(underflow_err), 32'(1));
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, PC_W'('h400 + 4*i), 1'b0, 1'b0, 1'b0, 1'b0);
      resolve_ok();
    end
    check("uf_sticky", 32'(underflow_err), 32'(1));
    do_reset();

    // Reset mid-operation kills the pending update pulse
    cycle(1'b1, PC_W'('h500), 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, PC_W'('h504), 1'b0, 1'b1, 1'b1, 1'b0);
    rstn = 1'b0;
    #1;
    check("rst_rslt_en", 32'(bus.rslt_en), 32'(0));
    check("rst_count", 32'(count), 32'(0));
    check("rst_resolve_cnt", 32'(resolve_cnt), 32'(0));
    check("rst_mispred_cnt", 32'(mispred_cnt), 32'(0));
    check("rst_enq_ready", 32'(bus.enq_ready), 32'(1));
    do_reset();

    // Random traffic; counters reach saturation along the way
    for (int n = 0; n < 3000; n++) begin
      bit ev, rv, rt, fl, pt;
      logic [PC_W-1:0] pc;
      ev = ($urandom_range(0, 99) < 60);
      rv = ($urandom_range(0, 99) < 50);
      fl = ($urandom_range(0, 99) < 3);
      pt = 1'($urandom_range(0, 1));
      pc = PC_W'($urandom_range(0, (1 << PC_W) - 1));
      rt = (model_q.size() != 0 && $urandom_range(0, 9) < 8) ? head_pred() : 1'($urandom_range(0, 1));
      cycle(ev, pc, pt, rv, rt, fl);
    end
    check("sat_resolve_cnt", 32'(resolve_cnt), 32'(SAT));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order queue of in-flight conditional-branch predictions sitting between fetch (which reads the gshare predictor) and the execute-stage branch unit. Each predicted branch is enqueued with its PC and predicted direction. When execute resolves the oldest branch, the queue drives the predictor's update port (`rslt_en`/`rslt_pc`/`rslt_taken`), flags a misprediction, and squashes all younger entries. It also keeps saturating statistics counters.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `PC_W`, 15: PC width; matches the predictor's PC port.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk` in 1: single clock; all state is updated on its rising edge.
- `rstn` in 1: reset, asynchronous and active-low.
- `enq_valid` in 1: fetch presents a predicted branch.
- `enq_pc` in PC_W: PC of the branch.
- `enq_pred_taken` in 1: predicted direction (the predictor's `pred_taken`).
- `enq_ready` out 1: queue not full.
- `res_valid` in 1: execute resolves the oldest outstanding branch.
- `res_taken` in 1: actual direction.
- `flush` in 1: external pipeline flush (exception/redirect).
- `rslt_en` out 1: predictor update strobe.
- `rslt_pc` out PC_W: PC of the resolved branch.
- `rslt_taken` out 1: actual direction of the resolved branch.
- `mispredict` out 1: one-cycle pulse, coincident with `rslt_en`.
- `count` out $clog2(DEPTH+1): number of valid entries.
- `underflow_err` out 1: sticky; set by `res_valid` while the queue is empty.
- `resolve_cnt` out CNT_W: saturating count of accepted resolutions.
- `mispred_cnt` out CNT_W: saturating count of mispredictions.

## Operation
- Storage: circular buffer of {pc, pred_taken}, with head and tail pointers of width log2(DEPTH) that wrap modulo DEPTH, plus a separate `count` register.
- Enqueue fires when `enq_valid && enq_ready`: the entry is written at tail and tail advances.
- `enq_ready = (count != DEPTH)`. It depends only on registered state, so a resolve in the same cycle does not free a slot for the enqueue.
- Resolve fires when `res_valid && count != 0`. The head entry is read and head advances.
  - Next cycle: `rslt_en=1`, `rslt_pc=head.pc`, `rslt_taken=res_taken`, `mispredict=(res_taken != head.pred_taken)`.
- Misprediction squash: all younger entries are discarded.
  - Next state: `count=0`, `tail=head+1`.
  - Any enqueue in the same cycle is dropped.
- `flush`:
  - Next state: `count=0`, `tail=head`.
  - A resolve accepted in the same cycle still advances head and is still reported on `rslt_*`/`mispredict`; it also sets `tail=head+1`.
  - An enqueue in the same cycle is dropped.
- Simultaneous enqueue and resolve with neither flush nor mispredict: `count` is unchanged and both pointers advance.
- `res_valid` while empty: no state change and no `rslt_en`; `underflow_err` is set and stays set until reset.
- Counters:
  - `resolve_cnt` increments once per accepted resolve.
  - `mispred_cnt` increments once per mispredict.
  - Both saturate at 2^CNT_W−1 with no wrap.

## Timing
- Reset values (asynchronous, `rstn=0`):
  - head=0, tail=0, count=0.
  - `enq_ready=1`, `rslt_en=0`, `rslt_pc=0`, `rslt_taken=0`, `mispredict=0`, `underflow_err=0`, `resolve_cnt=0`, `mispred_cnt=0`.
  - Entry storage need not be reset.
- Latency: resolve handshake at edge N → `rslt_*`/`mispredict` valid for exactly the cycle after edge N. This lines up with the predictor's registered update.
- `rslt_en` and `mispredict` are single-cycle pulses. Back-to-back resolves produce back-to-back pulses.
- An entry enqueued at edge N can be resolved at edge N+1 at the earliest (no bypass).
- `count` and `enq_ready` reflect post-edge state.
- Reset asserted mid-operation:
  - All state clears immediately.
  - No pending `rslt_en` survives.
  - After release, the queue starts empty.

## Test plan
- Reset, then enqueue PCs 0x0010, 0x0020, 0x0030 (predicted T, N, T); resolve T, N, T → three consecutive `rslt_en` pulses with `rslt_pc` 0x0010/0x0020/0x0030, `mispredict` always 0, `resolve_cnt=3`.
- Fill 4 entries → `enq_ready=0`, `count=4`. In that cycle assert `enq_valid` with resolve → the enqueue is rejected, `count=3`, `enq_ready=1` next cycle.
- Enqueue 0x0100 (predicted T) and 0x0104; resolve 0x0100 as not-taken → `mispredict=1`, `rslt_taken=0`, `count=0`, `mispred_cnt=1`. A concurrent enqueue of 0x0108 is dropped.
- Fill the queue; in one cycle assert `flush` and a resolve of the head, which is correct → `rslt_en=1` with the head PC, `count=0`. Then enqueue/resolve 6 more branches to confirm pointer wrap-around gives correct PCs.
- `res_valid` while empty → no `rslt_en`, `underflow_err=1`, which stays set through later traffic until `rstn` is pulsed.
- Assert `rstn` low in the cycle after a resolve handshake → `rslt_en` drops immediately, `count=0`, counters 0.
